rr_flit_arbiter: RTL



---
 rtl/noc_arb_pkg.sv | 41 ++++
 rtl/rr_flit_arbiter_if.sv | 28 ++
 rtl/rr_pick_onehot.sv | 29 ++
 rtl/rr_flit_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants and the wrap-around priority pick used by the NoC output-port arbiter.
package noc_arb_pkg;

  localparam int unsigned MAX_PORTS     = 16;
  localparam int unsigned NUM_PORTS_DEF = 5;

  // IDLE sits one bit above the per-port OWN bits in the one-hot state register.
  localparam int unsigned IDLE_IDX = NUM_PORTS_DEF;

  // Default router port indices; L (local) is searched first when leaving IDLE.
  localparam int unsigned N = 0;
  localparam int unsigned E = 1;
  localparam int unsigned W = 2;
  localparam int unsigned S = 3;
  localparam int unsigned L = 4;

  typedef logic [MAX_PORTS-1:0] req_vec_t;

  // First set request at or after start (wrapping modulo nports), returned one-hot.
  function automatic req_vec_t rr_pick(input req_vec_t req, input logic [3:0] start,
                                       input logic [4:0] nports);
    req_vec_t   pick;
    logic       found;
    logic [4:0] s;
    pick  = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (5'(k) < nports) begin
        s = {1'b0, start} + 5'(k);
        if (s >= nports) s = s - nports;
        if (!found && req[s[3:0]]) begin
          pick[s[3:0]] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_flit_arbiter_if.sv
// Request / flow-control bundle between the input ports, the arbiter and the downstream link.
interface rr_flit_arbiter_if #(
  parameter int NUM_PORTS = 5
);
  logic [NUM_PORTS-1:0] req;
  logic                 dcts;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] xbar_sel;
  logic                 rts;

  // Requesters / downstream side.
  modport master (
    output req,
    output dcts,
    input  grant,
    input  xbar_sel,
    input  rts
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  dcts,
    output grant,
    output xbar_sel,
    output rts
  );
endinterface

// File: rtl/rr_pick_onehot.sv
// Combinational wrap-around priority search: first request at or after i_start, one-hot.
module rr_pick_onehot
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = 5
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [3:0]           i_start,
  output logic [NUM_PORTS-1:0] o_pick
);

  req_vec_t w_req_ext;
  req_vec_t w_pick_ext;

  // Widen the request vector to the package search width.
  always_comb begin
    w_req_ext                = '0;
    w_req_ext[NUM_PORTS-1:0] = i_req;
  end

  assign w_pick_ext = rr_pick(w_req_ext, i_start, 5'(NUM_PORTS));
  assign o_pick     = w_pick_ext[NUM_PORTS-1:0];

  if (NUM_PORTS < MAX_PORTS) begin : g_unused
    logic w_unused_pick;
    assign w_unused_pick = |w_pick_ext[MAX_PORTS-1:NUM_PORTS];
  end

endmodule

// File: rtl/rr_flit_arbiter.sv
// Round-robin flit arbiter for one NoC router output port with RTS/DCTS handshake
// and an optional hold limit that forces rotation under continuous requests.
// Optional feature macro: ARB_STALL_CNT_EN adds o_stall_cnt (saturating count of stalled cycles).
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no owner, xbar_sel = 0, rts falls
//   OWN[i]  | port i owns the crossbar; rts/dcts moves one flit per handshake
module rr_flit_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 5,
  parameter int IDLE_FIRST = L,
  parameter int MAX_HOLD   = 0,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              rst,
  rr_flit_arbiter_if.slave arb
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16 || IDLE_FIRST < 0 || IDLE_FIRST >= NUM_PORTS ||
      MAX_HOLD < 0 || CNT_W < 1) begin : g_param_check
    $error("rr_flit_arbiter: illegal parameter combination");
  end

  localparam logic [NUM_PORTS:0] ST_IDLE = {1'b1, {NUM_PORTS{1'b0}}};

  logic [NUM_PORTS:0]   r_state;
  logic [NUM_PORTS:0]   w_state_nxt;
  logic                 r_rts;
  logic                 w_idle;
  logic [NUM_PORTS-1:0] w_own;
  logic [3:0]           w_own_idx;
  logic [3:0]           w_start;
  logic [NUM_PORTS-1:0] w_pick;
  logic                 w_stall;
  logic                 w_other_req;
  logic                 w_hold_hit;
  logic                 w_stay;
  logic                 w_state_chg;
  logic                 w_grant_any;

  assign w_idle      = r_state[NUM_PORTS];
  assign w_own       = r_state[NUM_PORTS-1:0];
  assign w_stall     = r_rts & ~arb.dcts;
  assign w_grant_any = r_rts & arb.dcts & ~w_idle;
  assign w_other_req = |(arb.req & ~w_own);
  assign w_stay      = ~w_idle & (|(arb.req & w_own)) & ~(w_hold_hit & w_other_req);
  assign w_state_chg = ~w_stall & (w_state_nxt != r_state);

  // Index of the owning port, used to start the search just past it.
  always_comb begin
    w_own_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_own[i]) w_own_idx = 4'(i);
    end
  end

  // From IDLE search starts at IDLE_FIRST; from OWN[i] at i+1 so that i itself comes last.
  assign w_start = w_idle ? 4'(IDLE_FIRST)
                 : (w_own_idx == 4'(NUM_PORTS - 1)) ? 4'd0 : w_own_idx + 4'd1;

  rr_pick_onehot #(
    .NUM_PORTS(NUM_PORTS)
  ) u_pick (
    .i_req  (arb.req),
    .i_start(w_start),
    .o_pick (w_pick)
  );

  // State register: frozen while a raised rts waits for dcts.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else if (!w_stall) r_state <= w_state_nxt;
  end

  // Next state: keep the owner, else hand over to the first requester found, else IDLE.
  always_comb begin
    w_state_nxt = '0;
    if (w_stay) w_state_nxt = r_state;
    else if (|w_pick) w_state_nxt[NUM_PORTS-1:0] = w_pick;
    else w_state_nxt[NUM_PORTS] = 1'b1;
  end

  // Outputs: select follows the owner; grant marks the cycle the handshake completes.
  always_comb begin
    arb.xbar_sel = w_own;
    arb.grant    = w_own & {NUM_PORTS{r_rts & arb.dcts}};
    arb.rts      = r_rts;
  end

  // rts rises one cycle after ownership and drops after each completed handshake.
  always_ff @(posedge clk) begin
    if (rst) r_rts <= 1'b0;
    else r_rts <= ~w_idle & ~(r_rts & arb.dcts);
  end

  if (MAX_HOLD > 0) begin : g_hold
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] r_hold;

    // Consecutive grants to the current owner; saturates when nobody else is waiting.
    always_ff @(posedge clk) begin
      if (rst) r_hold <= '0;
      else if (w_state_chg) r_hold <= '0;
      else if (w_grant_any && r_hold != HOLD_W'(MAX_HOLD)) r_hold <= r_hold + HOLD_W'(1);
    end

    assign w_hold_hit = (r_hold == HOLD_W'(MAX_HOLD));
  end else begin : g_no_hold
    assign w_hold_hit = 1'b0;
  end

`ifdef ARB_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Cycles spent with rts raised and dcts low, saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
